// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter: grant encoding, lock FSM
// states and a width helper for the saturating counters.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_t;

  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'b00,
    LOCK_LOCKED   = 2'b01,
    LOCK_YIELD    = 2'b10
  } lock_state_t;

  // Bits needed to hold every value 0..limit (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and a flag that is high while the count sits at LIMIT.
module arb_sat_counter
  import bus_arbiter_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // Next count: clear has priority; increments stop at LIMIT.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != LIMIT_V)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt      = cnt_reg;
  assign at_limit = (cnt_reg == LIMIT_V);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the Bridge bus. The CPU (m0) wins by
// default; the DMA engine (m1) is forced in after STARVE_LIMIT denied cycles
// and may hold the bus for up to MAX_BURST locked beats, after which it
// yields for exactly one cycle so a waiting CPU can get through.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int WAIT_W  = cnt_width(STARVE_LIMIT);
  localparam int BURST_W = cnt_width(MAX_BURST);
  // Count value of the beat that completes a full burst once it is granted.
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  gnt_t        gnt;
  lock_state_t state_reg;
  lock_state_t state_next;

  logic               force_m1;
  logic               lock_active;
  logic               yield;
  logic               m1_win;
  logic               wait_clr;
  logic               wait_at_limit;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               burst_clr;
  logic               burst_inc;
  logic               burst_at_limit;
  logic [BURST_W-1:0] burst_cnt;
  logic               unused_cnt_bits;

  assign lock_active = (state_reg == LOCK_LOCKED);
  assign yield       = (state_reg == LOCK_YIELD);
  assign force_m1    = (wait_at_limit || lock_active) && !yield;
  assign m1_win      = (gnt == GNT_M1);

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (m1_req && (!m0_req || force_m1)) begin
        gnt = GNT_M1;
      end else if (m0_req) begin
        gnt = GNT_M0;
      end
    end
  end

  // Route the granted master onto the bus and return read data only to it.
  always_comb begin
    bus_addr  = '0;
    bus_wen   = 1'b0;
    bus_wdata = '0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    case (gnt)
      GNT_M0: begin
        bus_addr  = m0_addr;
        bus_wen   = m0_wen;
        bus_wdata = m0_wdata;
        m0_rdata  = bus_rdata;
      end
      GNT_M1: begin
        bus_addr  = m1_addr;
        bus_wen   = m1_wen;
        bus_wdata = m1_wdata;
        m1_rdata  = bus_rdata;
      end
      default: begin
      end
    endcase
  end

  assign m0_stall = m0_req && !rst && (gnt != GNT_M0);
  assign m1_ack   = m1_win;

  // Starvation counter: counts cycles m1 is requesting but denied.
  assign wait_clr = !m1_req || m1_win;

  arb_sat_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (WAIT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (wait_clr),
    .inc      (!wait_clr),
    .cnt      (wait_cnt),
    .at_limit (wait_at_limit)
  );

  // Burst counter: number of locked m1 beats in the current burst.
  arb_sat_counter #(
    .LIMIT (MAX_BURST),
    .W     (BURST_W)
  ) u_burst_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (burst_clr),
    .inc      (burst_inc),
    .cnt      (burst_cnt),
    .at_limit (burst_at_limit)
  );

  // Only the flag of the wait counter and the value of the burst counter
  // drive decisions; the remaining outputs are deliberately sunk here.
  assign unused_cnt_bits = ^{wait_cnt, burst_at_limit};

  // Lock FSM next state and burst counter control. A locked beat that makes
  // the burst MAX_BURST long moves straight to the one-cycle yield.
  always_comb begin
    state_next = state_reg;
    burst_clr  = 1'b0;
    burst_inc  = 1'b0;
    case (state_reg)
      LOCK_UNLOCKED: begin
        if (m1_win && m1_lock) begin
          burst_inc  = 1'b1;
          state_next = (burst_cnt == BURST_LAST) ? LOCK_YIELD : LOCK_LOCKED;
        end
      end
      LOCK_LOCKED: begin
        if (!m1_req) begin
          state_next = LOCK_UNLOCKED;
          burst_clr  = 1'b1;
        end else if (m1_win && m1_lock) begin
          burst_inc = 1'b1;
          if (burst_cnt == BURST_LAST) begin
            state_next = LOCK_YIELD;
          end
        end else if (m1_win) begin
          state_next = LOCK_UNLOCKED;
          burst_clr  = 1'b1;
        end
      end
      LOCK_YIELD: begin
        state_next = LOCK_UNLOCKED;
        burst_clr  = 1'b1;
      end
      default: begin
        state_next = LOCK_UNLOCKED;
        burst_clr  = 1'b1;
      end
    endcase
  end

  // Lock state register; reset drops any lock in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOCK_UNLOCKED;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: inputs change 1 time unit after the rising
// edge, outputs are compared at the falling edge.
module tb_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_req = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic              m0_wen = 1'b0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_stall;
  logic              m1_req = 1'b0;
  logic              m1_lock = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic              m1_wen = 1'b0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wen;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata = '0;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (4),
    .MAX_BURST    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_wen    (m0_wen),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_stall  (m0_stall),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wen    (m1_wen),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_ack    (m1_ack),
    .bus_addr  (bus_addr),
    .bus_wen   (bus_wen),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic [31:0] addr,
                          input logic wen, input logic [31:0] wdata);
    m0_req   = req;
    m0_addr  = addr;
    m0_wen   = wen;
    m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic lock, input logic [31:0] addr,
                          input logic wen, input logic [31:0] wdata);
    m1_req   = req;
    m1_lock  = lock;
    m1_addr  = addr;
    m1_wen   = wen;
    m1_wdata = wdata;
  endtask

  task automatic go_idle();
    drive_m0(1'b0, 32'h0, 1'b0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset();
    drive_m0(1'b1, 32'h10, 1'b1, 32'h11);
    drive_m1(1'b1, 1'b1, 32'h20, 1'b1, 32'h22);
    bus_rdata = 32'hA5A5_A5A5;
    #2;
    checks++;
    if ({m0_stall, m1_ack, bus_wen} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: stall/ack/wen=%b expected 000", {m0_stall, m1_ack, bus_wen});
    end
    checks++;
    if ({bus_addr, bus_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h r0=%h r1=%h expected all 0",
               bus_addr, bus_wdata, m0_rdata, m1_rdata);
    end
    $display("reset held: stall=%b ack=%b addr=%h", m0_stall, m1_ack, bus_addr);
    drive_m0(1'b0, 32'h0, 1'b0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_m0_read();
    drive_m0(1'b1, 32'h4000, 1'b0, 32'h0);
    bus_rdata = 32'h1234;
    @(negedge clk);
    checks++;
    if (m0_rdata !== 32'h1234 || m0_stall !== 1'b0) begin
      errors++;
      $display("FAIL m0_read: rdata=%h stall=%b expected 00001234 0", m0_rdata, m0_stall);
    end
    checks++;
    if (bus_addr !== 32'h4000 || bus_wen !== 1'b0 || m1_ack !== 1'b0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL m0_read_bus: addr=%h wen=%b ack=%b r1=%h expected 00004000 0 0 0",
               bus_addr, bus_wen, m1_ack, m1_rdata);
    end
    $display("m0 read addr=%h rdata=%h stall=%b", bus_addr, m0_rdata, m0_stall);
    next_cycle();
    drive_m0(1'b1, 32'h4004, 1'b1, 32'hCAFE_0001);
    @(negedge clk);
    checks++;
    if (bus_wen !== 1'b1 || bus_addr !== 32'h4004 || bus_wdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL m0_write: wen=%b addr=%h wdata=%h expected 1 00004004 cafe0001",
               bus_wen, bus_addr, bus_wdata);
    end
    $display("m0 write addr=%h wdata=%h wen=%b", bus_addr, bus_wdata, bus_wen);
    go_idle();
  endtask

  task automatic test_starvation();
    drive_m0(1'b1, 32'h100, 1'b0, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      logic exp_ack;
      logic [31:0] exp_addr;
      exp_ack  = (c % 5 == 0);
      exp_addr = exp_ack ? 32'h200 : 32'h100;
      @(negedge clk);
      checks++;
      if (m1_ack !== exp_ack || m0_stall !== exp_ack || bus_addr !== exp_addr) begin
        errors++;
        $display("FAIL starve_c%0d: ack=%b stall=%b addr=%h expected %b %b %h",
                 c, m1_ack, m0_stall, bus_addr, exp_ack, exp_ack, exp_addr);
      end
      $display("starve cycle %0d: ack=%b stall=%b addr=%h", c, m1_ack, m0_stall, bus_addr);
      next_cycle();
    end
    go_idle();
  endtask

  task automatic test_locked_burst();
    drive_m0(1'b1, 32'h300, 1'b0, 32'h0);
    drive_m1(1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
    for (int c = 1; c <= 18; c++) begin
      logic exp_ack;
      exp_ack = (c >= 5 && c <= 12) || (c >= 17);
      @(negedge clk);
      checks++;
      if (m1_ack !== exp_ack || m0_stall !== exp_ack) begin
        errors++;
        $display("FAIL burst_c%0d: ack=%b stall=%b expected %b %b",
                 c, m1_ack, m0_stall, exp_ack, exp_ack);
      end
      $display("burst cycle %0d: ack=%b stall=%b", c, m1_ack, m0_stall);
      next_cycle();
    end
    go_idle();
  endtask

  task automatic test_m1_write();
    drive_m1(1'b1, 1'b0, 32'h4010, 1'b1, 32'hDEAD_BEEF);
    bus_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (bus_wen !== 1'b1 || bus_addr !== 32'h4010 || bus_wdata !== 32'hDEAD_BEEF || m1_ack !== 1'b1) begin
      errors++;
      $display("FAIL m1_write: wen=%b addr=%h wdata=%h ack=%b expected 1 00004010 deadbeef 1",
               bus_wen, bus_addr, bus_wdata, m1_ack);
    end
    $display("m1 write addr=%h wdata=%h ack=%b", bus_addr, bus_wdata, m1_ack);
    next_cycle();
    drive_m1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus_wen !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL m1_write_next: wen=%b ack=%b expected 0 0", bus_wen, m1_ack);
    end
    $display("after m1 write: wen=%b ack=%b", bus_wen, m1_ack);
    next_cycle();
    drive_m1(1'b1, 1'b0, 32'h4020, 1'b0, 32'h0);
    bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if (m1_rdata !== 32'h5555_AAAA || m0_rdata !== 32'h0 || m1_ack !== 1'b1) begin
      errors++;
      $display("FAIL m1_read: r1=%h r0=%h ack=%b expected 5555aaaa 0 1", m1_rdata, m0_rdata, m1_ack);
    end
    $display("m1 read rdata=%h ack=%b", m1_rdata, m1_ack);
    go_idle();
  endtask

  task automatic test_reset_mid_burst();
    drive_m1(1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      checks++;
      if (m1_ack !== 1'b1) begin
        errors++;
        $display("FAIL rstburst_beat%0d: ack=%b expected 1", b, m1_ack);
      end
      $display("pre-reset beat %0d: ack=%b", b, m1_ack);
      if (b < 3) next_cycle();
    end
    #1;
    rst = 1'b1;
    drive_m0(1'b1, 32'h600, 1'b1, 32'h77);
    bus_rdata = 32'h1111_2222;
    #1;
    checks++;
    if ({m0_stall, m1_ack, bus_wen} !== 3'b000 ||
        {bus_addr, bus_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL rst_async: stall=%b ack=%b wen=%b addr=%h wdata=%h r0=%h r1=%h expected all 0",
               m0_stall, m1_ack, bus_wen, bus_addr, bus_wdata, m0_rdata, m1_rdata);
    end
    $display("async reset: stall=%b ack=%b addr=%h", m0_stall, m1_ack, bus_addr);
    next_cycle();
    rst = 1'b0;
    drive_m0(1'b1, 32'h600, 1'b0, 32'h0);
    for (int c = 1; c <= 13; c++) begin
      logic exp_ack;
      exp_ack = (c >= 5 && c <= 12);
      @(negedge clk);
      checks++;
      if (m1_ack !== exp_ack || m0_stall !== exp_ack) begin
        errors++;
        $display("FAIL post_rst_c%0d: ack=%b stall=%b expected %b %b",
                 c, m1_ack, m0_stall, exp_ack, exp_ack);
      end
      $display("post-reset cycle %0d: ack=%b stall=%b", c, m1_ack, m0_stall);
      next_cycle();
    end
    go_idle();
  endtask

  task automatic test_idle_clears_wait();
    drive_m0(1'b1, 32'h700, 1'b0, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h800, 1'b0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (m1_ack !== 1'b0 || m0_stall !== 1'b0) begin
        errors++;
        $display("FAIL prewait_c%0d: ack=%b stall=%b expected 0 0", c, m1_ack, m0_stall);
      end
      $display("pre-idle cycle %0d: ack=%b stall=%b", c, m1_ack, m0_stall);
      next_cycle();
    end
    drive_m0(1'b0, 32'h700, 1'b1, 32'h99);
    drive_m1(1'b0, 1'b0, 32'h800, 1'b1, 32'h88);
    @(negedge clk);
    checks++;
    if (bus_addr !== 32'h0 || bus_wen !== 1'b0 || bus_wdata !== 32'h0 ||
        m0_stall !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_bus: addr=%h wen=%b wdata=%h stall=%b ack=%b expected all 0",
               bus_addr, bus_wen, bus_wdata, m0_stall, m1_ack);
    end
    $display("idle: addr=%h wen=%b wdata=%h", bus_addr, bus_wen, bus_wdata);
    next_cycle();
    drive_m0(1'b1, 32'h700, 1'b0, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h800, 1'b0, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      logic exp_ack;
      exp_ack = (c == 5);
      @(negedge clk);
      checks++;
      if (m1_ack !== exp_ack) begin
        errors++;
        $display("FAIL wait_clear_c%0d: ack=%b expected %b", c, m1_ack, exp_ack);
      end
      $display("post-idle cycle %0d: ack=%b", c, m1_ack);
      next_cycle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_starvation();
    test_locked_burst();
    test_m1_write();
    test_reset_mid_burst();
    test_idle_clears_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single CPU-side Bridge bus (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata) between the CPU data port (master 0) and a DMA/loader engine (master 1). It sits between myCPU and Bridge in miniRV_SoC. The CPU has default priority, and master 1 can lock the bus for bounded bursts. A starvation counter guarantees master 1 forward progress; the CPU is stalled whenever it requests but is not granted.

## Interface
- ADDR_W, 32, address width of all buses
- DATA_W, 32, data width of all buses
- STARVE_LIMIT, 4, consecutive denied m1 cycles before m1 is forced in (≥1)
- MAX_BURST, 8, maximum consecutive locked m1 grants (≥1)
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  CPU bus access this cycle
- m0_addr  in  ADDR_W  CPU address
- m0_wen  in  1  CPU write enable
- m0_wdata  in  DATA_W  CPU write data
- m0_rdata  out  DATA_W  read data to CPU
- m0_stall  out  1  CPU must hold its access and retry
- m1_req  in  1  DMA access this cycle
- m1_lock  in  1  DMA requests to keep the bus for the next beat
- m1_addr / m1_wen / m1_wdata  in  ADDR_W/1/DATA_W  DMA access
- m1_rdata  out  DATA_W  read data to DMA
- m1_ack  out  1  DMA access completes this cycle
- bus_addr / bus_wen / bus_wdata  out  ADDR_W/1/DATA_W  to Bridge
- bus_rdata  in  DATA_W  from Bridge, combinational

## Operation
- Grant (combinational from inputs and registered state): gnt = M1 if m1_req and (!m0_req or force_m1); else M0 if m0_req; else NONE.
- force_m1 = (wait_cnt == STARVE_LIMIT) or lock_active; force_m1 = 0 while yield is set.
- Bus mux: the granted master's addr/wen/wdata drive the bus. On NONE: bus_addr=0, bus_wen=0, bus_wdata=0.
- m0_rdata = bus_rdata if gnt==M0, else 0. m1_rdata = bus_rdata if gnt==M1, else 0.
- m0_stall = m0_req & (gnt != M0). m1_ack = (gnt == M1).
- wait_cnt: cleared if !m1_req or gnt==M1; otherwise +1, saturating at STARVE_LIMIT.
- Lock state machine, states UNLOCKED / LOCKED / YIELD:
  - UNLOCKED→LOCKED: on gnt==M1 & m1_lock. burst_cnt←1.
  - LOCKED: each gnt==M1 & m1_lock increments burst_cnt. When burst_cnt reaches MAX_BURST, go to YIELD.
  - LOCKED→UNLOCKED: on gnt==M1 with m1_lock=0, or on !m1_req. burst_cnt←0.
  - YIELD: lasts exactly one cycle, with lock_active=0 and force off (M0 wins if requesting). Then UNLOCKED, burst_cnt←0, wait_cnt unaffected.
- Lock never blocks m1 if m0 is idle.

## Timing
- Zero-latency combinational path: a granted access completes in the same cycle. Reads return bus_rdata that cycle. Writes commit at the closing clk edge.
- Stalled master must hold req/addr/wen/wdata stable until granted.
- Reset (async): state=UNLOCKED, wait_cnt=0, burst_cnt=0. While rst=1, gnt=NONE and all outputs are 0 (including m0_stall and m1_ack).
- Reset mid-burst drops the lock. m1 re-arbitrates from UNLOCKED.
- Simultaneous m0_req & m1_req with no force: M0 wins, and m1 waits.
- Worst-case m0 stall = MAX_BURST cycles. Worst-case m1 wait with m0 continuously requesting = STARVE_LIMIT cycles.

## Structure
- Shared package/defines: gnt encoding (NONE=2'b00, M0=2'b01, M1=2'b10) and lock state encoding (UNLOCKED, LOCKED, YIELD).
- One sub-module: arb_sat_counter (parameterised saturating counter with clear/inc/limit flag). Instantiate it for wait_cnt and burst_cnt.
- Grant logic, lock state machine and bus mux stay in bus_arbiter.

## Test plan
- m0_req only, read addr 0x4000, bus_rdata=0x1234 → gnt M0, m0_rdata=0x1234, m0_stall=0, bus_wen=0.
- m0_req and m1_req held continuously, STARVE_LIMIT=4 → m1_ack exactly on cycle 5 of waiting. m0_stall=1 that cycle only, and the pattern repeats every 5 cycles.
- m1 locked burst with m0_req asserted, MAX_BURST=8 → 8 consecutive m1_ack, then one YIELD cycle with M0 granted (m0_stall=0), then m1 regains the lock.
- m1 write 0xDEADBEEF to 0x4010 with m0 idle → bus_wen=1, bus_addr=0x4010, m1_ack=1 in the same cycle. Next cycle bus_wen=0.
- rst asserted asynchronously at burst beat 3 → all outputs 0 immediately. After release, m0 wins a simultaneous request, and burst_cnt restarts at 1.
- Both requests deasserted → bus_addr/wen/wdata=0, m0_stall=0, m1_ack=0, and wait_cnt clears.
